// File: rtl/cmd_master.sv
// cmd_master: turns register read/write requests into byte frames on a simple
// tx/rx byte link. A header byte {~we, addr} is sent first. A write then sends
// four data bytes, MSB first. A read collects four rx bytes, MSB first.
// Optional read-response timeout: define CMD_MASTER_TIMEOUT_EN to enable it.
module cmd_master #(
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        req_we,
    input  logic [6:0]  req_addr,
    input  logic [31:0] req_wdat,
    output logic        busy,
    output logic        done,
    output logic [31:0] rdat,
    output logic        timeout,
    output logic [7:0]  txData,
    output logic        txSend,
    input  logic        txBusy,
    input  logic [7:0]  rxData,
    input  logic        rxValid
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HDR   = 3'd1,
        ST_WDATA = 3'd2,
        ST_RDATA = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t       state_q, state_d;
    logic         we_q, we_d;
    logic [6:0]   addr_q, addr_d;
    logic [31:0]  wdat_q, wdat_d;
    logic [1:0]   cnt_q, cnt_d;
    logic [23:0]  shift_q, shift_d;
    logic [31:0]  rdat_q, rdat_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;
    logic [7:0]   tx_data_q, tx_data_d;
    logic         tx_send_q, tx_send_d;
    logic         rx_valid_q, rx_valid_d;
    logic         tx_ok_s;
    logic         rx_edge_s;

`ifdef CMD_MASTER_TIMEOUT_EN
    // Counter holds 0 .. TIMEOUT_CYCLES-1; reaching the last value ends the read.
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic          timeout_q, timeout_d;
`endif

    // Select write-data byte idx, most significant byte first.
    function automatic logic [7:0] wr_byte(input logic [31:0] w, input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = w[31:24];
            2'd1:    b = w[23:16];
            2'd2:    b = w[15:8];
            2'd3:    b = w[7:0];
            default: b = w[7:0];
        endcase
        return b;
    endfunction

    // A byte may go out only when the link is free and no strobe went out last cycle.
    assign tx_ok_s   = ~txBusy & ~tx_send_q;
    // New rx byte is a rising edge of the rxValid level.
    assign rx_edge_s = rxValid & ~rx_valid_q;

    // Next-state and registered-output logic for the transaction FSM.
    always_comb begin
        state_d    = state_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdat_d     = wdat_q;
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        rdat_d     = rdat_q;
        tx_data_d  = tx_data_q;
        tx_send_d  = 1'b0;
        rx_valid_d = rxValid;
`ifdef CMD_MASTER_TIMEOUT_EN
        tmo_cnt_d  = tmo_cnt_q;
        timeout_d  = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    we_d    = req_we;
                    addr_d  = req_addr;
                    wdat_d  = req_wdat;
                    state_d = ST_HDR;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_HDR: begin
                if (tx_ok_s) begin
                    tx_send_d = 1'b1;
                    tx_data_d = {~we_q, addr_q};
                    cnt_d     = 2'd0;
`ifdef CMD_MASTER_TIMEOUT_EN
                    tmo_cnt_d = {TW{1'b0}};
`endif
                    if (we_q) begin
                        state_d = ST_WDATA;
                    end else begin
                        state_d = ST_RDATA;
                    end
                end else begin
                    state_d = ST_HDR;
                end
            end
            ST_WDATA: begin
                if (tx_ok_s) begin
                    tx_send_d = 1'b1;
                    tx_data_d = wr_byte(wdat_q, cnt_q);
                    if (cnt_q == 2'd3) begin
                        state_d = ST_DONE;
                    end else begin
                        cnt_d = cnt_q + 2'd1;
                    end
                end else begin
                    state_d = ST_WDATA;
                end
            end
            ST_RDATA: begin
                if (rx_edge_s) begin
                    shift_d = {shift_q[15:0], rxData};
`ifdef CMD_MASTER_TIMEOUT_EN
                    tmo_cnt_d = {TW{1'b0}};
`endif
                    if (cnt_q == 2'd3) begin
                        rdat_d  = {shift_q, rxData};
                        state_d = ST_DONE;
                    end else begin
                        cnt_d = cnt_q + 2'd1;
                    end
                end else begin
`ifdef CMD_MASTER_TIMEOUT_EN
                    if (tmo_cnt_q == TMO_LAST) begin
                        timeout_d = 1'b1;
                        state_d   = ST_DONE;
                    end else begin
                        tmo_cnt_d = tmo_cnt_q + {{(TW-1){1'b0}}, 1'b1};
                    end
`else
                    state_d = ST_RDATA;
`endif
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    // State and output registers; reset aborts any transaction in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            we_q       <= 1'b0;
            addr_q     <= 7'd0;
            wdat_q     <= 32'd0;
            cnt_q      <= 2'd0;
            shift_q    <= 24'd0;
            rdat_q     <= 32'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            tx_data_q  <= 8'd0;
            tx_send_q  <= 1'b0;
            rx_valid_q <= 1'b0;
`ifdef CMD_MASTER_TIMEOUT_EN
            tmo_cnt_q  <= {TW{1'b0}};
            timeout_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdat_q     <= wdat_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            rdat_q     <= rdat_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            tx_data_q  <= tx_data_d;
            tx_send_q  <= tx_send_d;
            rx_valid_q <= rx_valid_d;
`ifdef CMD_MASTER_TIMEOUT_EN
            tmo_cnt_q  <= tmo_cnt_d;
            timeout_q  <= timeout_d;
`endif
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign rdat   = rdat_q;
    assign txData = tx_data_q;
    assign txSend = tx_send_q;
`ifdef CMD_MASTER_TIMEOUT_EN
    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_cmd_master.sv
// Randomized self-checking bench for cmd_master. Link-side models: a transmitter
// that stays busy busy_len cycles after each strobe, and a receiver that returns
// read bytes as rxValid rising edges. Expectations come from the frame rules.
module tb_cmd_master;

`ifdef CMD_MASTER_TIMEOUT_EN
    localparam int TMO = 100;
`else
    localparam int TMO = 65535;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic        req_we;
    logic [6:0]  req_addr;
    logic [31:0] req_wdat;
    logic        busy;
    logic        done;
    logic [31:0] rdat;
    logic        timeout;
    logic [7:0]  txData;
    logic        txSend;
    logic        txBusy;
    logic [7:0]  rxData;
    logic        rxValid;

    cmd_master #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .req_we   (req_we),
        .req_addr (req_addr),
        .req_wdat (req_wdat),
        .busy     (busy),
        .done     (done),
        .rdat     (rdat),
        .timeout  (timeout),
        .txData   (txData),
        .txSend   (txSend),
        .txBusy   (txBusy),
        .rxData   (rxData),
        .rxValid  (rxValid)
    );

    always #5 clk = ~clk;

    int         n_cmp = 0;
    int         n_err = 0;
    int         busy_len = 0;
    int         bcnt = 0;
    int         cyc = 0;
    logic       prev_send = 1'b0;
    logic [7:0] tx_q[$];
    int         tx_t[$];
    logic [31:0] exp_rdat = 32'd0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Transmitter model: capture each strobe, check the guard, then stay busy.
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            bcnt      = 0;
            txBusy    = 1'b0;
            prev_send = 1'b0;
        end else begin
            if (txSend) begin
                check_eq("tx_guard", {30'd0, txBusy, prev_send}, 32'd0);
                tx_q.push_back(txData);
                tx_t.push_back(cyc);
                bcnt = busy_len;
            end else if (bcnt > 0) begin
                bcnt--;
            end
            txBusy    = (bcnt > 0);
            prev_send = txSend;
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic rx_byte(input logic [7:0] b, input bit last);
        rxValid = 1'b0;
        rxData  = 8'($urandom);
        repeat (1 + $urandom_range(0, 3)) tick();
        rxData  = b;
        rxValid = 1'b1;
        if (!last) begin
            repeat (1 + $urandom_range(0, 2)) tick();
        end
    endtask

    task automatic wait_header();
        int n = 0;
        while (tx_q.size() == 0 && n < 100) begin
            tick();
            n++;
        end
        check_eq("hdr_seen", {31'd0, tx_q.size() != 0}, 32'd1);
    endtask

    // One full transaction; hold keeps req high so the next call chains on.
    task automatic do_txn(input logic we, input logic [6:0] addr, input logic [31:0] wdat,
                          input logic [31:0] rb, input bit hold, input bit pre_high);
        logic [7:0] exp_q[$];
        bit         found = 0;
        int         gap;
        tx_q.delete();
        tx_t.delete();
        if (pre_high) rxValid = 1'b1;
        req      = 1'b1;
        req_we   = we;
        req_addr = addr;
        req_wdat = wdat;
        @(posedge clk);
        #1;
        check_eq("accept_busy", {31'd0, busy}, 32'd1);
        if (!hold) req = 1'b0;
        req_we   = 1'($urandom);
        req_addr = 7'($urandom);
        req_wdat = $urandom;
        if (!we) begin
            wait_header();
            for (int i = 0; i < 4; i++) rx_byte(rb[31-8*i -: 8], i == 3);
        end
        for (int n = 0; n < 300 && !found; n++) begin
            tick();
            if (done) found = 1;
            else if (we) begin
                rxValid = 1'($urandom);
                rxData  = 8'($urandom);
            end
        end
        check_eq("done_seen", {31'd0, found}, 32'd1);
        if (found) begin
            if (!we) exp_rdat = rb;
            check_eq("done_busy", {31'd0, busy}, 32'd1);
            check_eq("done_tmo", {31'd0, timeout}, 32'd0);
            check_eq("rdat", rdat, exp_rdat);
            tick();
            check_eq("done_width", {31'd0, done}, 32'd0);
            check_eq("idle_busy", {31'd0, busy}, 32'd0);
        end
        exp_q.push_back({~we, addr});
        if (we) for (int i = 0; i < 4; i++) exp_q.push_back(wdat[31-8*i -: 8]);
        check_eq("tx_count", tx_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < tx_q.size(); i++) begin
            check_eq("tx_byte", {24'd0, tx_q[i]}, {24'd0, exp_q[i]});
            if (i > 0) begin
                gap = (busy_len + 1 > 2) ? busy_len + 1 : 2;
                check_eq("tx_gap", tx_t[i] - tx_t[i-1], gap);
            end
        end
    endtask

    initial begin
        bit   found;
        int   n;
        logic we;
        bit   hold;
        rst      = 1'b1;
        req      = 1'b0;
        req_we   = 1'b0;
        req_addr = 7'd0;
        req_wdat = 32'd0;
        rxData   = 8'd0;
        rxValid  = 1'b0;
        repeat (3) tick();
        check_eq("rst_flags", {28'd0, busy, done, txSend, timeout}, 32'd0);
        check_eq("rst_txdata", {24'd0, txData}, 32'd0);
        check_eq("rst_rdat", rdat, 32'd0);
        rst = 1'b0;
        repeat (2) tick();

        // Directed: basic write, basic read, write against a slow transmitter.
        busy_len = 0;
        do_txn(1'b1, 7'h12, 32'hDEADBEEF, 32'd0, 0, 0);
        do_txn(1'b0, 7'h05, 32'd0, 32'h01234567, 0, 0);
        busy_len = 3;
        do_txn(1'b1, 7'h2A, 32'hCAFEF00D, 32'd0, 0, 0);
        busy_len = 0;

        // req held across two transactions: second one accepted right after done.
        do_txn(1'b1, 7'h31, 32'h11223344, 32'd0, 1, 0);
        do_txn(1'b0, 7'h7F, 32'd0, 32'h55667788, 0, 0);
        tick();

        // Reset in the middle of a read: no done, busy drops at once.
        tx_q.delete();
        req = 1'b1; req_we = 1'b0; req_addr = 7'h33;
        @(posedge clk);
        #1;
        req = 1'b0;
        wait_header();
        rx_byte(8'h11, 0);
        rx_byte(8'h22, 0);
        tick();
        rst = 1'b1;
        #1;
        check_eq("abort_busy", {31'd0, busy}, 32'd0);
        check_eq("abort_done", {31'd0, done}, 32'd0);
        check_eq("abort_rdat", rdat, 32'd0);
        exp_rdat = 32'd0;
        repeat (2) tick();
        rst = 1'b0;
        found = 0;
        repeat (6) begin
            tick();
            if (done) found = 1;
        end
        check_eq("abort_nodone", {31'd0, found}, 32'd0);
        do_txn(1'b0, 7'h05, 32'd0, 32'hAABBCCDD, 0, 0);

`ifdef CMD_MASTER_TIMEOUT_EN
        // Read that stalls after two bytes must time out ~TMO cycles later.
        tx_q.delete();
        req = 1'b1; req_we = 1'b0; req_addr = 7'h44;
        @(posedge clk);
        #1;
        req = 1'b0;
        wait_header();
        rx_byte(8'h99, 0);
        rx_byte(8'h88, 1);
        found = 0;
        n = 0;
        while (!found && n < 400) begin
            tick();
            n++;
            rxValid = 1'b0;
            if (done) found = 1;
        end
        check_eq("tmo_seen", {31'd0, found}, 32'd1);
        check_eq("tmo_latency", {31'd0, (n >= TMO - 1) && (n <= TMO + 3)}, 32'd1);
        check_eq("tmo_flag", {31'd0, timeout}, 32'd1);
        check_eq("tmo_rdat", rdat, exp_rdat);
        tick();
        check_eq("tmo_clear", {30'd0, done, timeout}, 32'd0);
`endif

        // Randomized transactions, sometimes chained with req held high.
        for (int t = 0; t < 24; t++) begin
            we       = 1'($urandom);
            hold     = (t < 23) && ($urandom_range(0, 3) == 0);
            busy_len = $urandom_range(0, 4);
            do_txn(we, 7'($urandom), $urandom, $urandom, hold, 1'($urandom));
            if (!hold) begin
                repeat ($urandom_range(0, 3)) begin
                    rxValid = 1'($urandom);
                    rxData  = 8'($urandom);
                    tick();
                end
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/cmd_master.md
CMD_MASTER -- requirements
Module: cmd_master

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 65535, read-response timeout in clk cycles, used only with CMD_MASTER_TIMEOUT_EN.
REQ-002 SHALL have port clk  input  1  main clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port req  input  1  request strobe, sampled only in IDLE.
REQ-005 SHALL have port req_we  input  1  1 = write, 0 = read.
REQ-006 SHALL have port req_addr  input  7  register address.
REQ-007 SHALL have port req_wdat  input  32  write data.
REQ-008 SHALL have port busy  output  1  high from request accept until the done pulse, inclusive.
REQ-009 SHALL have port done  output  1  one-cycle completion pulse.
REQ-010 SHALL have port rdat  output  32  read result, valid from done and held until the next read completes.
REQ-011 SHALL have port timeout  output  1  high with done when a read aborted; only with CMD_MASTER_TIMEOUT_EN, else tied 0.
REQ-012 SHALL have port txData  output  8  low-level tx byte.
REQ-013 SHALL have port txSend  output  1  low-level one-cycle transmit strobe.
REQ-014 SHALL have port txBusy  input  1  low-level transmitter busy.
REQ-015 SHALL have port rxData  input  8  low-level rx byte.
REQ-016 SHALL have port rxValid  input  1  low-level rx byte valid, level; new byte = rising edge.

Function
REQ-017 SHALL implement states IDLE, HDR, WDATA, RDATA, DONE.
REQ-018 IDLE: req=1 SHALL latch req_we/req_addr/req_wdat, set busy, go HDR next cycle; req=0 stays IDLE.
REQ-019 Header byte SHALL be {~req_we, req_addr}: bit7=1 read, 0 write.
REQ-020 Transmit rule: txSend SHALL pulse for exactly one cycle with txData stable, only when txBusy=0 and no pulse occurred in the preceding cycle (one-cycle guard).
REQ-021 HDR: after header pulse, write SHALL go WDATA; read SHALL go RDATA and clear the rx byte counter.
REQ-022 WDATA: SHALL send wdat[31:24], [23:16], [15:8], [7:0] in order, each under REQ-020, then go DONE.
REQ-023 RDATA: SHALL detect rxValid rising edge (registered copy of rxValid), shift rxData in MSB first, go DONE after 4th byte.
REQ-024 rxValid edges SHALL be ignored in all states but RDATA; rxValid high already when RDATA entered SHALL NOT count.
REQ-025 rdat SHALL update only on successful read completion, all 32 bits in the cycle entering DONE.
REQ-026 DONE: done=1 one cycle, busy=1, then IDLE with busy=0; earliest next accept is the cycle after.
REQ-027 req asserted while busy SHALL be ignored, not queued.
REQ-028 Header-to-first-data latency SHALL be bounded only by txBusy; zero added cycles beyond the guard.

Reset
REQ-029 rst=1 SHALL immediately force IDLE; busy=0, done=0, timeout=0, txSend=0, txData=0, rdat=0, byte counter=0, rxValid copy=0, timeout counter=0.
REQ-030 rst mid-transaction SHALL abort with no done pulse; partial frame left on link is not recovered.

Configuration
REQ-031 Macro CMD_MASTER_TIMEOUT_EN defined: RDATA SHALL count cycles from entry, reset on each byte; on reaching TIMEOUT_CYCLES go DONE with timeout=1, rdat unchanged.
REQ-032 Macro undefined: no counter, RDATA waits indefinitely, timeout output constant 0.

Verification
REQ-033 Write req_addr=0x12, req_wdat=0xDEADBEEF, txBusy idle -> tx bytes 0x12,0xDE,0xAD,0xBE,0xEF, single done, timeout=0.
REQ-034 Read req_addr=0x05, bench returns 0x01,0x23,0x45,0x67 -> tx byte 0x85, rdat=0x01234567 at done.
REQ-035 Write with txBusy held 3 cycles after each pulse -> no txSend while txBusy=1, byte order intact, one pulse per byte.
REQ-036 Assert rst after 2nd read byte -> busy=0 immediately, no done; next read of 0xAABBCCDD completes correctly.
REQ-037 CMD_MASTER_TIMEOUT_EN, TIMEOUT_CYCLES=100, read, 2 bytes then silence -> done+timeout ~100 cycles after 2nd byte, rdat keeps prior value.
REQ-038 req held high continuously over two transactions -> second accepted exactly the cycle after done's cycle.
